// File: rtl/out_port_buffer_pkg.sv
// -----------------------------------------------------------------------------
// out_port_buffer_pkg
//   Shared constants for the processor output path. These are the default
//   widths and depth used by out_port_buffer and its storage array. The same
//   values are used by the processor top, so OUT_Port and the queued byte
//   width always agree.
// -----------------------------------------------------------------------------
package out_port_buffer_pkg;

  // Width of one OUT byte. This must equal the processor's OUT_Port width.
  localparam int DEF_DATA_W = 8;

  // Default FIFO depth. It must be a power of two and at least 2.
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  // Width of the saturating dropped-byte counter.
  localparam int DEF_CNT_W  = 8;

endpackage : out_port_buffer_pkg

// File: rtl/out_fifo_mem.sv
// -----------------------------------------------------------------------------
// out_fifo_mem
//   A DEPTH x DATA_W register array. It has one synchronous write port and one
//   asynchronous read port. The asynchronous read gives the parent
//   first-word fall-through without any extra cycle of latency.
// Ports
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  array contents at raddr (combinational)
// -----------------------------------------------------------------------------
module out_fifo_mem
  import out_port_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset on purpose. The read pointer and the
  // empty flag decide whether an entry is visible, so its power-up contents
  // never matter. Leaving it unreset also lets the array map onto plain
  // flops or a register file with no reset fan-out.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : out_fifo_mem

// File: rtl/out_port_buffer.sv
// -----------------------------------------------------------------------------
// out_port_buffer
//   Output-side buffer placed directly after the processor top.
//   - It captures every WB-stage OUT write (Valid/OUT_Port).
//   - It queues the bytes in a FIFO and drains them over valid/ready.
//   - It never back-pressures the core. A byte that arrives while the FIFO is
//     full and nothing is being popped is dropped. Each drop is counted in a
//     saturating counter and flagged with a sticky overflow bit.
// Ports
//   clk, rst      clock and asynchronous active-high reset
//   in_valid      processor Valid (WB output valid)
//   in_data       processor OUT_Port
//   out_ready     consumer accepts out_data this cycle
//   out_valid     a byte is queued; out_data is the oldest one
//   out_data      FIFO head (first-word fall-through); 0 while empty
//   full, empty   occupancy flags
//   count         occupied entries, 0..DEPTH
//   overflow      sticky: at least one byte was dropped
//   drop_cnt      number of dropped bytes, saturating at 2^CNT_W-1
//   clr_overflow  synchronous clear of overflow and drop_cnt
// -----------------------------------------------------------------------------
module out_port_buffer
  import out_port_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              clr_overflow
);

  // Each pointer carries one wrap bit above the address bits. Equal pointers
  // mean the FIFO is empty. Pointers that differ only in the wrap bit mean it
  // is full. Because both pointers roll over together modulo 2*DEPTH, this
  // test stays correct after any number of wraps.
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] head_data;

  // ---------------------------------------------------------------------------
  // Occupancy and handshake
  // ---------------------------------------------------------------------------
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // The pointer difference modulo 2*DEPTH is exactly the occupancy 0..DEPTH.
  // It tracks count + push - pop without a separate counter that could drift.
  assign count = wr_ptr_q - rd_ptr_q;

  // out_valid depends only on registered state. A byte written at an edge
  // therefore appears one cycle later, and no path runs from in_* to out_*.
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts a byte
  // then. A drop happens only when no slot will be freed.
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  // Force the output to 0 while empty. This keeps unreset storage from
  // showing on the port and gives out_data = 0 out of reset.
  assign out_data = empty ? '0 : head_data;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  out_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (head_data)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first. This
  // guarantees that no path through the block leaves a value unassigned, so
  // no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end

    // The drop is evaluated after the clear and increments from the cleared
    // value. A drop that coincides with clr_overflow therefore leaves
    // overflow = 1 and drop_cnt = 1.
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != {CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_d + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then sample their next-state values from the same edge, regardless of
  // the order in which the blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule : out_port_buffer

// File: tb/tb_out_port_buffer.sv
// -----------------------------------------------------------------------------
// tb_out_port_buffer
//   Self-checking bench for out_port_buffer. A queue-based reference model
//   decides, cycle by cycle, which bytes are accepted, popped and dropped. The
//   DUT outputs are compared against that model 1 time unit after every
//   rising edge. Directed scenarios cover latency, ordering, overflow,
//   clear-vs-drop, saturation, and asynchronous reset. A random phase
//   exercises pointer wrap.
// -----------------------------------------------------------------------------
module tb_out_port_buffer;
  import out_port_buffer_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int D  = DEF_DEPTH;
  localparam int AW = DEF_ADDR_W;
  localparam int CW = DEF_CNT_W;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic [CW-1:0] drop_cnt;

  out_port_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the queued bytes, oldest first, plus the overflow state.
  logic [DW-1:0] mq[$];
  bit            m_ov;
  int            m_dc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = mq.size();
    check({tag, ".valid"}, 32'(out_valid), 32'(sz != 0));
    check({tag, ".count"}, 32'(count), 32'(sz));
    check({tag, ".full"}, 32'(full), 32'(sz == D));
    check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
    check({tag, ".dcnt"}, 32'(drop_cnt), 32'(m_dc));
    if (sz != 0) begin
      check({tag, ".data"}, 32'(out_data), 32'(mq[0]));
    end
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, then
  // compare. Push, pop and drop are decided from the model's occupancy before
  // the edge.
  task automatic step(input bit iv, input logic [DW-1:0] d, input bit rdy,
                      input bit clr, input string tag);
    int sz;
    bit m_pop, m_push, m_drop;
    in_valid     = iv;
    in_data      = d;
    out_ready    = rdy;
    clr_overflow = clr;
    @(posedge clk);
    sz     = mq.size();
    m_pop  = rdy && (sz > 0);
    m_push = iv && ((sz < D) || m_pop);
    m_drop = iv && (sz == D) && !m_pop;
    if (m_pop) begin
      void'(mq.pop_front());
    end
    if (m_push) begin
      mq.push_back(d);
    end
    if (clr) begin
      m_ov = 1'b0;
      m_dc = 0;
    end
    if (m_drop) begin
      m_ov = 1'b1;
      if (m_dc < CNT_MAX) begin
        m_dc++;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic model_clear();
    mq.delete();
    m_ov = 1'b0;
    m_dc = 0;
  endtask

  // Assert reset a little after an edge, check the reset state, and release
  // it away from the next edge.
  task automatic do_reset();
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    rst          = 1'b1;
    model_clear();
    #1;
    check_all("rst");
    check("rst.data0", 32'(out_data), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic fill_seq(input string tag);
    for (int i = 1; i <= D; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, tag);
    end
  endtask

  task automatic drain_expect_seq(input string tag);
    for (int i = 1; i <= D; i++) begin
      check({tag, ".order"}, 32'(out_data), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0, tag);
    end
    check({tag, ".empty_end"}, 32'(empty), 32'h1);
  endtask

  initial begin
    model_clear();
    #2;
    do_reset();

    // 1: single byte, one-cycle latency, held stable while not ready.
    step(1'b1, 8'hA5, 1'b0, 1'b0, "t1_wr");
    check("t1.valid", 32'(out_valid), 32'h1);
    check("t1.data", 32'(out_data), 32'hA5);
    check("t1.count", 32'(count), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, "t1_hold");
      check("t1.stable", 32'(out_data), 32'hA5);
    end

    // 2: fill and drain in order.
    do_reset();
    fill_seq("t2_fill");
    check("t2.full", 32'(full), 32'h1);
    check("t2.count8", 32'(count), 32'(D));
    drain_expect_seq("t2_drain");

    // 3: overflow while full; the queued contents are unchanged.
    do_reset();
    fill_seq("t3_fill");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hE0 + DW'(i), 1'b0, 1'b0, "t3_drop");
    end
    check("t3.ovf", 32'(overflow), 32'h1);
    check("t3.dcnt", 32'(drop_cnt), 32'h3);
    drain_expect_seq("t3_drain");

    // 4: a push with a pop while full is accepted, with no drop.
    do_reset();
    fill_seq("t4_fill");
    step(1'b1, 8'h55, 1'b1, 1'b0, "t4_pp");
    check("t4.count", 32'(count), 32'(D));
    check("t4.dcnt", 32'(drop_cnt), 32'h0);
    for (int i = 2; i <= D; i++) begin
      check("t4.order", 32'(out_data), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0, "t4_drain");
    end
    check("t4.last55", 32'(out_data), 32'h55);
    step(1'b0, '0, 1'b1, 1'b0, "t4_drain");

    // 5: a drop wins over a coincident clear, a lone clear zeroes, then
    // the counter saturates.
    fill_seq("t5_fill");
    step(1'b1, 8'h11, 1'b0, 1'b0, "t5_drop");
    step(1'b1, 8'h22, 1'b0, 1'b1, "t5_clrdrop");
    check("t5.ovf_clrdrop", 32'(overflow), 32'h1);
    check("t5.dcnt_clrdrop", 32'(drop_cnt), 32'h1);
    step(1'b0, '0, 1'b0, 1'b1, "t5_clr");
    check("t5.ovf_clr", 32'(overflow), 32'h0);
    check("t5.dcnt_clr", 32'(drop_cnt), 32'h0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, "t5_sat");
    end
    check("t5.sat", 32'(drop_cnt), 32'(CNT_MAX));

    // 6: an asynchronous reset mid-cycle empties the FIFO at once.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h30 + DW'(i), 1'b0, 1'b0, "t6_q");
    end
    #3;
    rst = 1'b1;
    model_clear();
    #1;
    check("t6.async_valid", 32'(out_valid), 32'h0);
    check("t6.async_count", 32'(count), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1'b1, 8'hC3, 1'b0, 1'b0, "t6_c3");
    check("t6.c3", 32'(out_data), 32'hC3);
    step(1'b0, '0, 1'b1, 1'b0, "t6_pop");

    // Random push/pop with occasional clears; the model tracks wrap.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), "rand");
    end
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) != 0),
           1'b0, "rand2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_out_port_buffer
